// File: rtl/slice_seq_adder.sv
`default_nettype none
// ============================================================================
// Module      : slice_seq_adder
// Description : Multi-cycle WIDTH-bit adder that pushes one 4-bit slice per
//               cycle through a ripple-carry add and returns {cout,sum} over a
//               valid/ready handshake. Define SLICE_ADD_OVF_EN to add the
//               signed-overflow output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module slice_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SLICE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] c_last = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic [3:0]       w_sa;
    logic [3:0]       w_sb;
    logic [3:0]       w_ss;
    logic             w_slice_cout;
    logic             w_accept;
    logic             w_last;
`ifdef SLICE_ADD_OVF_EN
    logic             r_ovf;
    logic             w_msb_cin;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_last    = (r_cnt == c_last);

    // Pick the operand slice addressed by the counter.
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (r_cnt == CW'(k)) begin
                w_sa = r_a[4*k +: 4];
                w_sb = r_b[4*k +: 4];
            end
        end
    end

    // Four-bit ripple-carry cell; the carry chain is kept in a local variable.
    always_comb begin
        logic v_c;
        v_c  = r_carry;
        w_ss = '0;
`ifdef SLICE_ADD_OVF_EN
        w_msb_cin = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
`ifdef SLICE_ADD_OVF_EN
            if (i == 3) w_msb_cin = v_c;
`endif
            w_ss[i] = w_sa[i] ^ w_sb[i] ^ v_c;
            v_c     = (w_sa[i] & w_sb[i]) | (v_c & (w_sa[i] ^ w_sb[i]));
        end
        w_slice_cout = v_c;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_cout  <= 1'b0;
        end else if (r_state == S_RUN) begin
            for (int k = 0; k < NSLICE; k++) begin
                if (r_cnt == CW'(k)) r_sum[4*k +: 4] <= w_ss;
            end
            r_carry <= w_slice_cout;
            // Counter parks on the last slice so it never wraps inside RUN.
            if (w_last) begin
                r_cout <= w_slice_cout;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef SLICE_ADD_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= w_msb_cin ^ w_slice_cout;
        end
    end

    assign ovf = r_ovf;
`else
    // Overflow tracking is compiled out in this configuration.
`endif

endmodule
`default_nettype wire
